// File: rtl/elgamal_encrypting_entity.sv
// ElGamal sender: holds a public key (p, g, h) and turns each plaintext m into (g^k, m*h^k) mod p.
// Define ELGAMAL_CONST_TIME_EN for a fixed exponentiation latency that does not depend on k.
module elgamal_encrypting_entity #(
  parameter int               SIZE      = 64,
  parameter logic [SIZE-1:0]  LFSR_POLY = 64'hD800000000000000,
  parameter logic [SIZE-1:0]  LFSR_SEED = 64'h1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] input_p_tdata,
  input  logic [SIZE-1:0] input_g_tdata,
  input  logic [SIZE-1:0] input_h_tdata,
  input  logic            input_key_tvalid,
  output logic            input_key_tready,
  input  logic [SIZE-1:0] input_msg_tdata,
  input  logic            input_msg_tvalid,
  output logic            input_msg_tready,
  output logic [SIZE-1:0] output_c1_tdata,
  output logic [SIZE-1:0] output_c2_tdata,
  output logic            output_err,
  output logic            output_tvalid,
  input  logic            output_tready
);

`ifdef ELGAMAL_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [2:0] {NOKEY, IDLE, DRAW, EXP_SQ, EXP_MUL, MSG_MUL, OUT} state_t;

  state_t          state, state_next;
  logic [SIZE-1:0] lfsr, p_reg, g_reg, h_reg, mask;
  logic [SIZE-1:0] m_reg, k_reg, x, y, acc0, acc1;
  logic [SIZE-1:0] mul_b0, mul_b1, step0, step1, k_cand;
  logic [CW-1:0]   cnt, idx;
  logic [2:0]      draw_cnt;
  logic            key_fire, msg_fire, msg_bad, k_ok, draw_gate, mul_last, bit_k;

  // One interleaved shift-add step of a*b mod p; r and a are already reduced below p.
  function automatic logic [SIZE-1:0] mm_step(input logic [SIZE-1:0] r, input logic [SIZE-1:0] a,
                                              input logic b, input logic [SIZE-1:0] md);
    logic [SIZE:0] t, pm;
    pm = {1'b0, md};
    t  = {r, 1'b0};
    if (t >= pm) t = t - pm;
    if (b) t = t + {1'b0, a};
    if (t >= pm) t = t - pm;
    return t[SIZE-1:0];
  endfunction

  function automatic logic [SIZE-1:0] msb_mask(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] r;
    r = v;
    for (int s = 1; s < SIZE; s = s * 2) r = r | (r >> s);
    return r;
  endfunction

  function automatic logic [SIZE-1:0] reduce_once(input logic [SIZE-1:0] v, input logic [SIZE-1:0] md);
    return (v >= md) ? v - md : v;
  endfunction

  function automatic logic [SIZE-1:0] lfsr_step(input logic [SIZE-1:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

  assign input_key_tready = !rst && (state == NOKEY || state == IDLE);
  assign input_msg_tready = (state == IDLE) && !input_key_tvalid;
  assign key_fire  = input_key_tvalid && input_key_tready;
  assign msg_fire  = input_msg_tvalid && input_msg_tready;
  assign msg_bad   = (p_reg < SIZE'(3)) || (input_msg_tdata >= p_reg) || (input_msg_tdata == '0);
  assign k_cand    = lfsr & mask;
  assign draw_gate = CONST_TIME ? (draw_cnt == 3'd3) : 1'b1;
  assign k_ok      = draw_gate && (k_cand != '0) && (k_cand <= p_reg - SIZE'(2));
  assign mul_last  = (cnt == '0);
  assign bit_k     = k_reg[idx];

  // Both multipliers share the bit counter; unit 0 tracks g^k, unit 1 tracks h^k then m*h^k.
  always_comb begin
    mul_b0 = x;
    mul_b1 = y;
    case (state)
      EXP_MUL: begin mul_b0 = g_reg; mul_b1 = h_reg; end
      MSG_MUL: mul_b1 = m_reg;
      default: ;
    endcase
    step0 = mm_step(acc0, x, mul_b0[cnt], p_reg);
    step1 = mm_step(acc1, y, mul_b1[cnt], p_reg);
  end

  always_comb begin
    state_next = state;
    case (state)
      NOKEY:   if (key_fire) state_next = IDLE;
      IDLE:    if (msg_fire) state_next = msg_bad ? OUT : DRAW;
      DRAW:    if (k_ok) state_next = EXP_SQ;
      EXP_SQ:
        if (mul_last) begin
          if (bit_k || CONST_TIME) state_next = EXP_MUL;
          else if (idx == '0)      state_next = MSG_MUL;
          else                     state_next = EXP_SQ;
        end
      EXP_MUL: if (mul_last) state_next = (idx == '0) ? MSG_MUL : EXP_SQ;
      MSG_MUL: if (mul_last) state_next = OUT;
      OUT:     if (output_tready) state_next = IDLE;
      default: state_next = NOKEY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= NOKEY;
      lfsr            <= LFSR_SEED;
      p_reg           <= '0;
      g_reg           <= '0;
      h_reg           <= '0;
      mask            <= '0;
      draw_cnt        <= '0;
      output_c1_tdata <= '0;
      output_c2_tdata <= '0;
      output_err      <= 1'b0;
      output_tvalid   <= 1'b0;
    end else begin
      state    <= state_next;
      lfsr     <= lfsr_step(lfsr);
      draw_cnt <= (state != DRAW) ? 3'd0 : (draw_cnt == 3'd3) ? 3'd3 : draw_cnt + 3'd1;
      if (key_fire) begin
        p_reg <= input_p_tdata;
        g_reg <= reduce_once(input_g_tdata, input_p_tdata);
        h_reg <= reduce_once(input_h_tdata, input_p_tdata);
        mask  <= msb_mask(input_p_tdata);
      end
      if (state == IDLE && msg_fire && msg_bad) begin
        output_c1_tdata <= '0;
        output_c2_tdata <= '0;
        output_err      <= 1'b1;
        output_tvalid   <= 1'b1;
      end
      if (state == MSG_MUL && mul_last) begin
        output_c1_tdata <= x;
        output_c2_tdata <= step1;
        output_err      <= 1'b0;
        output_tvalid   <= 1'b1;
      end
      if (state == OUT && output_tready) output_tvalid <= 1'b0;
    end
  end

  // Exponentiation datapath: left-to-right square-and-multiply, one bit of k per EXP_SQ visit.
  always_ff @(posedge clk) begin
    if (msg_fire) m_reg <= input_msg_tdata;
    case (state)
      DRAW:
        if (k_ok) begin
          k_reg <= k_cand;
          x     <= SIZE'(1);
          y     <= SIZE'(1);
          idx   <= CW'(SIZE - 1);
          cnt   <= CW'(SIZE - 1);
          acc0  <= '0;
          acc1  <= '0;
        end
      EXP_SQ, EXP_MUL, MSG_MUL:
        if (!mul_last) begin
          cnt  <= cnt - CW'(1);
          acc0 <= step0;
          acc1 <= step1;
        end else begin
          cnt  <= CW'(SIZE - 1);
          acc0 <= '0;
          acc1 <= '0;
          case (state)
            EXP_SQ: begin
              x <= step0;
              y <= step1;
              if (!CONST_TIME && !bit_k && idx != '0) idx <= idx - CW'(1);
            end
            EXP_MUL: begin
              if (bit_k) begin
                x <= step0;
                y <= step1;
              end
              if (idx != '0) idx <= idx - CW'(1);
            end
            default: y <= step1;
          endcase
        end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_elgamal_encrypting_entity.sv
// Directed bench for elgamal_encrypting_entity at SIZE = 16 with an independent LFSR and modexp model.
module tb_elgamal_encrypting_entity;
  localparam int          SIZE = 16;
  localparam logic [15:0] POLY = 16'hB400;
  localparam logic [15:0] SEED = 16'h0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] p_data = '0, g_data = '0, h_data = '0, msg_data = '0;
  logic        key_tvalid = 1'b0, msg_tvalid = 1'b0, out_ready = 1'b1;
  logic        key_tready, msg_tready, out_err, out_tvalid;
  logic [15:0] c1, c2;

  int n_checks = 0;
  int n_fail   = 0;

  longint kp, kg, kh, kx;
  logic [15:0] m_lfsr;

  elgamal_encrypting_entity #(.SIZE(SIZE), .LFSR_POLY(POLY), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst),
    .input_p_tdata(p_data), .input_g_tdata(g_data), .input_h_tdata(h_data),
    .input_key_tvalid(key_tvalid), .input_key_tready(key_tready),
    .input_msg_tdata(msg_data), .input_msg_tvalid(msg_tvalid), .input_msg_tready(msg_tready),
    .output_c1_tdata(c1), .output_c2_tdata(c2), .output_err(out_err),
    .output_tvalid(out_tvalid), .output_tready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_next(m_lfsr);

  function automatic longint modpow(input longint b, input longint e, input longint md);
    longint r = 1;
    b = b % md;
    while (e > 0) begin
      if (e % 2 == 1) r = (r * b) % md;
      b = (b * b) % md;
      e = e / 2;
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  // k the DUT must draw, given the model LFSR value just before the message handshake edge
  task automatic model_k(input logic [15:0] lf, output longint k, output int tries);
    logic [15:0] v, msk, c;
    msk = 0;
    while (longint'(msk) < kp) msk = (msk << 1) | 16'h1;
    v = lfsr_next(lf);
    k = 0;
    tries = 0;
    for (int i = 0; i < 5000; i++) begin
      c = v & msk;
      if (c >= 1 && longint'(c) <= kp - 2) begin
        k = longint'(c);
        tries = i;
        break;
      end
      v = lfsr_next(v);
    end
  endtask

  task automatic load_key(input longint p, input longint g, input longint h, input longint x);
    @(negedge clk);
    p_data = 16'(p); g_data = 16'(g); h_data = 16'(h);
    key_tvalid = 1'b1;
    #1;
    check_eq("key_tready", key_tready, 1);
    @(posedge clk);
    #1 key_tvalid = 1'b0;
    kp = p; kg = g; kh = h; kx = x;
  endtask

  task automatic send_msg(input logic [15:0] mv, output logic [15:0] lf);
    int n;
    n = 0;
    @(negedge clk);
    msg_data = mv;
    msg_tvalid = 1'b1;
    #1;
    while (!msg_tready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("msg_accept", msg_tready, 1);
    lf = m_lfsr;
    @(posedge clk);
    #1 msg_tvalid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit busy_rdy);
    lat = 0;
    busy_rdy = 1'b0;
    while (lat < 3000) begin
      @(negedge clk);
      lat++;
      if (out_tvalid) break;
      if (msg_tready) busy_rdy = 1'b1;
    end
    if (!out_tvalid) check_eq("out_timeout", 0, 1);
  endtask

  task automatic expect_pair(input string tag, input longint mv, input logic [15:0] lf);
    longint k, e1, e2, s;
    int t;
    model_k(lf, k, t);
    e1 = modpow(kg, k, kp);
    e2 = (mv * modpow(kh, k, kp)) % kp;
    check_eq({tag, "_err"}, out_err, 0);
    check_eq({tag, "_c1"}, c1, e1);
    check_eq({tag, "_c2"}, c2, e2);
    check_eq({tag, "_c1_range"}, (c1 >= 1 && longint'(c1) < kp), 1);
    s = modpow(longint'(c1), kx, kp);
    check_eq({tag, "_decrypt"}, (longint'(c2) * modpow(s, kp - 2, kp)) % kp, mv);
  endtask

  task automatic run_msg(input string tag, input longint mv);
    logic [15:0] lf;
    int lat;
    bit busy;
    send_msg(16'(mv), lf);
    wait_out(lat, busy);
    check_eq({tag, "_busy_tready"}, busy, 0);
    expect_pair(tag, mv, lf);
    @(negedge clk);
    check_eq({tag, "_tvalid_clear"}, out_tvalid, 0);
  endtask

  task automatic run_bad(input string tag, input longint mv);
    logic [15:0] lf;
    int lat;
    bit busy;
    send_msg(16'(mv), lf);
    wait_out(lat, busy);
    check_eq({tag, "_latency"}, lat, 1);
    check_eq({tag, "_err"}, out_err, 1);
    check_eq({tag, "_c1"}, c1, 0);
    check_eq({tag, "_c2"}, c2, 0);
    @(negedge clk);
    check_eq({tag, "_tvalid_clear"}, out_tvalid, 0);
  endtask

  initial begin
    logic [15:0] lf, s1, s2;
    int lat, t;
    bit busy, moved, rdy_seen;
    longint k;

    repeat (3) @(negedge clk);
    check_eq("rst_tvalid", out_tvalid, 0);
    check_eq("rst_c1", c1, 0);
    check_eq("rst_c2", c2, 0);
    check_eq("rst_err", out_err, 0);
    check_eq("rst_msg_tready", msg_tready, 0);
    check_eq("rst_key_tready", key_tready, 0);
    rst = 1'b0;
    msg_tvalid = 1'b1;
    msg_data = 16'd3;
    rdy_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1 if (msg_tready) rdy_seen = 1'b1;
    end
    check_eq("nokey_msg_tready", rdy_seen, 0);
    check_eq("nokey_key_tready", key_tready, 1);
    msg_tvalid = 1'b0;

    load_key(23, 5, 8, 6);
    run_msg("m10", 10);

    for (int i = 1; i <= 20; i++) run_msg($sformatf("seq%0d", i), i);

    run_bad("m_eq_p", 23);
    run_bad("m_zero", 0);

    out_ready = 1'b0;
    send_msg(16'd13, lf);
    wait_out(lat, busy);
    expect_pair("stall", 13, lf);
    s1 = c1;
    s2 = c2;
    moved = 1'b0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (c1 != s1 || c2 != s2 || !out_tvalid) moved = 1'b1;
      if (msg_tready) rdy_seen = 1'b1;
    end
    check_eq("stall_stable", moved, 0);
    check_eq("stall_msg_tready", rdy_seen, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("stall_release_tvalid", out_tvalid, 0);
    check_eq("stall_back_idle", msg_tready, 1);

    // key and message offered together: key wins, message follows under the new key
    p_data = 16'd29; g_data = 16'd2; h_data = 16'd3;
    key_tvalid = 1'b1;
    msg_data = 16'd7;
    msg_tvalid = 1'b1;
    #1;
    check_eq("both_key_tready", key_tready, 1);
    check_eq("both_msg_tready", msg_tready, 0);
    @(posedge clk);
    kp = 29; kg = 2; kh = 3; kx = 5;
    @(negedge clk);
    key_tvalid = 1'b0;
    #1;
    check_eq("both_msg_next", msg_tready, 1);
    lf = m_lfsr;
    @(posedge clk);
    #1 msg_tvalid = 1'b0;
    wait_out(lat, busy);
    expect_pair("newkey", 7, lf);
    @(negedge clk);

    // reset in the middle of the first squaring pass
    send_msg(16'd11, lf);
    model_k(lf, k, t);
    repeat (t + 9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_tvalid", out_tvalid, 0);
    check_eq("arst_c1", c1, 0);
    check_eq("arst_c2", c2, 0);
    check_eq("arst_err", out_err, 0);
    check_eq("arst_msg_tready", msg_tready, 0);
    check_eq("arst_key_tready", key_tready, 0);
    @(negedge clk);
    rst = 1'b0;
    msg_data = 16'd5;
    msg_tvalid = 1'b1;
    rdy_seen = 1'b0;
    busy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (msg_tready) rdy_seen = 1'b1;
      if (out_tvalid) busy = 1'b1;
    end
    msg_tvalid = 1'b0;
    check_eq("after_rst_msg_tready", rdy_seen, 0);
    check_eq("after_rst_no_output", busy, 0);
    check_eq("after_rst_key_tready", key_tready, 1);
    load_key(23, 5, 8, 6);
    run_msg("reload", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elgamal_encrypting_entity.md
Name: elgamal_encrypting_entity

Overview:
- Sender side of the ElGamal link. Accepts a public key (p, g, h = g^x mod p) once, then encrypts each plaintext word m into a ciphertext pair.
- For each message it draws an ephemeral k from an internal LFSR and returns c1 = g^k mod p and c2 = m·h^k mod p.
- Uses AXI-stream style valid/ready on all channels. The ciphertext pair feeds the decrypting entity.

Parameters:
- SIZE, 64, word width of p, g, h, m, c1, c2, k.
- LFSR_POLY, 64'hD800000000000000, Galois feedback taps (SIZE bits).
- LFSR_SEED, 64'h1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- input_p_tdata  in  SIZE  prime modulus p
- input_g_tdata  in  SIZE  group generator g
- input_h_tdata  in  SIZE  receiver public key h
- input_key_tvalid  in  1  key triple valid
- input_key_tready  out  1  key triple accepted when high with tvalid
- input_msg_tdata  in  SIZE  plaintext m
- input_msg_tvalid  in  1  plaintext valid
- input_msg_tready  out  1  plaintext accepted
- output_c1_tdata  out  SIZE  c1
- output_c2_tdata  out  SIZE  c2
- output_err  out  1  ciphertext invalid; qualified by output_tvalid
- output_tvalid  out  1  c1/c2/err valid
- output_tready  in  1  downstream accepts pair

Behaviour:
- Reset: async, active-high.
  - All outputs 0, state NOKEY, LFSR = LFSR_SEED, key registers 0.
  - Reset mid-operation aborts the operation; the pending ciphertext is lost.
- LFSR: free-runs one Galois step every cycle from reset, independent of state.
- States: NOKEY, IDLE, DRAW, EXP_SQ, EXP_MUL, MSG_MUL, OUT.
- NOKEY:
  - input_key_tready = 1, input_msg_tready = 0.
  - On key handshake: latch p, g, h; compute mask = all ones from bit 0 up to MSB of p; go to IDLE.
- IDLE:
  - input_key_tready = 1 and input_msg_tready = 1.
  - If both tvalid are high in the same cycle, key wins: msg tready is forced 0 that cycle; stay in IDLE with the new key.
  - On msg handshake: latch m.
    - If p < 3 or m ≥ p or m == 0: go to OUT with c1 = c2 = 0, err = 1.
    - Else go to DRAW.
- DRAW:
  - Each cycle: k_cand = LFSR & mask.
  - If 1 ≤ k_cand ≤ p−2: latch k, set x = 1, y = 1, bit index i = SIZE−1, go to EXP_SQ.
  - Else retry next cycle.
- EXP_SQ: two parallel modular multipliers compute x = x·x mod p and y = y·y mod p. Takes SIZE cycles, then go to EXP_MUL.
- EXP_MUL:
  - If k[i] = 1: x = x·g mod p, y = y·h mod p, taking SIZE cycles.
  - If k[i] = 0: skip in 0 cycles (see feature).
  - Then if i == 0 go to MSG_MUL; else decrement i and go to EXP_SQ.
- MSG_MUL: y = m·y mod p, SIZE cycles, then go to OUT.
- Modular multiply a·b mod p: interleaved MSB-first shift-add over SIZE cycles.
  - Per step: r = 2r; if r ≥ p then r −= p; if b[j] then r += a; if r ≥ p then r −= p.
  - Internal width SIZE+1 bits, no overflow.
  - Precondition a, b < p; inputs g and h ≥ p are first reduced by one conditional subtraction at key load.
- OUT:
  - output_c1_tdata = x, output_c2_tdata = y, output_tvalid = 1. Outputs are registered.
  - Both tready are 0; data holds stable until output_tready.
  - On handshake: output_tvalid = 0 the next cycle, go to IDLE. The key is retained.
- Key is replaced only in NOKEY or IDLE. Messages are never lost or duplicated.

Optional Feature:
- Macro: ELGAMAL_CONST_TIME_EN.
- Defined:
  - EXP_MUL always runs its SIZE-cycle multiply. When k[i] = 0 the product is discarded and x, y are unchanged.
  - DRAW always waits until the LFSR step count reaches 4 before accepting a k_cand.
  - Result: EXP + MSG latency is fixed at 2·SIZE·SIZE + SIZE cycles.
- Undefined: the multiply is skipped for zero bits, so latency depends on popcount(k).
- Results are identical either way.

Test Plan:
- Setup: SIZE = 16. Load key p = 23, g = 5, h = 8 (x = 6). Send m = 10.
  - Require output_err = 0, 1 ≤ c1 < 23, and bench decrypt c2·(c1^6)^−1 mod 23 = 10.
  - Also require c1 equals g^k for the LFSR-model k.
- Send 20 messages 1..20 back-to-back with output_tready always 1.
  - Require every pair to decrypt correctly, no msg dropped, and input_msg_tready = 0 outside IDLE.
- Send m = 23, then m = 0.
  - Require output_tvalid with err = 1, c1 = c2 = 0, and no DRAW entered.
- Hold output_tready = 0 for 50 cycles in OUT.
  - Require c1/c2 stable, msg tready = 0; handshake on the first cycle tready = 1.
- Assert input_key_tvalid and input_msg_tvalid together in IDLE.
  - Require the key is accepted, msg tready = 0 that cycle, and the msg is accepted the next cycle under the new key.
- Assert rst during EXP_SQ.
  - Require all outputs 0 immediately (async), state NOKEY, and msg tready = 0 until a key is reloaded.
- With ELGAMAL_CONST_TIME_EN: keys k = 1 and k = 0x3F give equal cycle counts from msg handshake to output_tvalid.
